// File: rtl/ahb_master_skid_fifo_if.sv
// Producer/consumer handshake bundle for the AHB master skid FIFO.
// The slave modport is the FIFO side; the master modport is the side driving pushes and consuming the head.
interface ahb_master_skid_fifo_if #(
    parameter int WDT   = 32,
    parameter int DEPTH = 4
);
    logic                     i_flush;
    logic                     i_valid;
    logic [WDT-1:0]           i_data;
    logic                     o_stall;
    logic                     o_valid;
    logic [WDT-1:0]           o_data;
    logic                     i_stall;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_overflow;

    modport slave (
        input  i_flush, i_valid, i_data, i_stall,
        output o_stall, o_valid, o_data, o_count, o_overflow
    );

    modport master (
        output i_flush, i_valid, i_data, i_stall,
        input  o_stall, o_valid, o_data, o_count, o_overflow
    );
endinterface

// File: rtl/ahb_master_skid_fifo.sv
// DEPTH-entry fall-through FIFO for the AHB master path; push-to-head latency 1 cycle, no bypass.
// Registered o_stall rises early enough that a producer reacting within SKID cycles never overflows; drops while full set a sticky flag.
module ahb_master_skid_fifo #(
    parameter int WDT   = 32,
    parameter int DEPTH = 4,
    parameter int SKID  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    ahb_master_skid_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] C_STALL  = CW'(DEPTH - SKID);

    logic [WDT-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_stall;
    logic           r_overflow;

    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic [CW-1:0]  w_count_next;

    assign w_pop        = (r_count != '0) && !bus.i_stall;
    assign w_push       = bus.i_valid && ((r_count < C_FULL) || w_pop);
    assign w_drop       = bus.i_valid && !w_push;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (bus.i_flush) begin
            // Flush wins over any same-cycle push/pop; storage is left as-is.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_stall <= (w_count_next >= C_STALL);
        end
    end

    assign bus.o_stall    = r_stall;
    assign bus.o_valid    = (r_count != '0);
    assign bus.o_data     = r_mem[r_rd_ptr];
    assign bus.o_count    = r_count;
    assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_ahb_master_skid_fifo.sv
// Directed bench for ahb_master_skid_fifo at DEPTH=4, SKID=1, WDT=32.
module tb_ahb_master_skid_fifo;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    ahb_master_skid_fifo_if #(.WDT(32), .DEPTH(4)) bus ();

    ahb_master_skid_fifo #(.WDT(32), .DEPTH(4), .SKID(1)) dut (
        .i_clk    (clk),
        .i_resetn (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_stall = 1'b0;
        #3;
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_in_valid got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 32'h0) begin n_bad++; $display("FAIL rst_in_data got %h want 0", bus.o_data); end
        #20;
        rst_n = 1'b1;
        repeat (3) step();
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall got %b want 0", bus.o_stall); end
        n_cmp++; if (bus.o_count !== 3'd0) begin n_bad++; $display("FAIL idle_count got %0d want 0", bus.o_count); end
        n_cmp++; if (bus.o_data !== 32'h0) begin n_bad++; $display("FAIL idle_data got %h want 0", bus.o_data); end
        n_cmp++; if (bus.o_overflow !== 1'b0) begin n_bad++; $display("FAIL idle_ovf got %b want 0", bus.o_overflow); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2;
        bus.i_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1; bus.i_data = exp_d[i];
            step();
            n_cmp++; if (bus.o_data !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data%0d got %h want %h", i, bus.o_data, exp_d[i]); end
            n_cmp++; if (bus.o_count !== 3'd1) begin n_bad++; $display("FAIL b2b_count%0d got %0d want 1", i, bus.o_count); end
            n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid%0d got %b want 1", i, bus.o_valid); end
        end
        bus.i_valid = 1'b0;
        step();
        n_cmp++; if (bus.o_count !== 3'd0) begin n_bad++; $display("FAIL b2b_drain_count got %0d want 0", bus.o_count); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain_valid got %b want 0", bus.o_valid); end
    endtask

    task automatic test_fill_overflow();
        logic [2:0] exp_cnt [5];
        logic       exp_stl [5];
        logic       exp_ovf [5];
        exp_cnt[0] = 3'd1; exp_stl[0] = 1'b0; exp_ovf[0] = 1'b0;
        exp_cnt[1] = 3'd2; exp_stl[1] = 1'b0; exp_ovf[1] = 1'b0;
        exp_cnt[2] = 3'd3; exp_stl[2] = 1'b1; exp_ovf[2] = 1'b0;
        exp_cnt[3] = 3'd4; exp_stl[3] = 1'b1; exp_ovf[3] = 1'b0;
        exp_cnt[4] = 3'd4; exp_stl[4] = 1'b1; exp_ovf[4] = 1'b1;
        bus.i_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.i_valid = 1'b1; bus.i_data = 32'hB0 + 32'(i);
            step();
            n_cmp++; if (bus.o_count !== exp_cnt[i]) begin n_bad++; $display("FAIL fill_count%0d got %0d want %0d", i, bus.o_count, exp_cnt[i]); end
            n_cmp++; if (bus.o_stall !== exp_stl[i]) begin n_bad++; $display("FAIL fill_stall%0d got %b want %b", i, bus.o_stall, exp_stl[i]); end
            n_cmp++; if (bus.o_overflow !== exp_ovf[i]) begin n_bad++; $display("FAIL fill_ovf%0d got %b want %b", i, bus.o_overflow, exp_ovf[i]); end
            n_cmp++; if (bus.o_data !== 32'hB0) begin n_bad++; $display("FAIL fill_head%0d got %h want b0", i, bus.o_data); end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic test_full_push_pop();
        bus.i_stall = 1'b0; bus.i_valid = 1'b1; bus.i_data = 32'hC0;
        step();
        bus.i_valid = 1'b0; bus.i_stall = 1'b1;
        n_cmp++; if (bus.o_count !== 3'd4) begin n_bad++; $display("FAIL fullpp_count got %0d want 4", bus.o_count); end
        n_cmp++; if (bus.o_data !== 32'hB1) begin n_bad++; $display("FAIL fullpp_head got %h want b1", bus.o_data); end
        n_cmp++; if (bus.o_overflow !== 1'b1) begin n_bad++; $display("FAIL fullpp_ovf got %b want 1", bus.o_overflow); end
        n_cmp++; if (bus.o_stall !== 1'b1) begin n_bad++; $display("FAIL fullpp_stall got %b want 1", bus.o_stall); end
    endtask

    task automatic test_drain();
        logic [31:0] exp_d [4];
        logic [2:0]  exp_cnt [4];
        logic        exp_stl [4];
        exp_d[0] = 32'hB2; exp_cnt[0] = 3'd3; exp_stl[0] = 1'b1;
        exp_d[1] = 32'hB3; exp_cnt[1] = 3'd2; exp_stl[1] = 1'b0;
        exp_d[2] = 32'hC0; exp_cnt[2] = 3'd1; exp_stl[2] = 1'b0;
        exp_d[3] = 32'h0;  exp_cnt[3] = 3'd0; exp_stl[3] = 1'b0;
        bus.i_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) begin
                n_cmp++; if (bus.o_data !== exp_d[i]) begin n_bad++; $display("FAIL drain_head%0d got %h want %h", i, bus.o_data, exp_d[i]); end
            end
            n_cmp++; if (bus.o_count !== exp_cnt[i]) begin n_bad++; $display("FAIL drain_count%0d got %0d want %0d", i, bus.o_count, exp_cnt[i]); end
            n_cmp++; if (bus.o_stall !== exp_stl[i]) begin n_bad++; $display("FAIL drain_stall%0d got %b want %b", i, bus.o_stall, exp_stl[i]); end
        end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %b want 0", bus.o_valid); end
    endtask

    task automatic test_flush();
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1; bus.i_data = 32'hF0 + 32'(i);
            step();
        end
        n_cmp++; if (bus.o_count !== 3'd3) begin n_bad++; $display("FAIL preflush_count got %0d want 3", bus.o_count); end
        n_cmp++; if (bus.o_stall !== 1'b1) begin n_bad++; $display("FAIL preflush_stall got %b want 1", bus.o_stall); end
        n_cmp++; if (bus.o_overflow !== 1'b1) begin n_bad++; $display("FAIL preflush_ovf got %b want 1", bus.o_overflow); end
        bus.i_flush = 1'b1; bus.i_valid = 1'b1; bus.i_data = 32'hD0;
        step();
        bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_stall = 1'b0;
        n_cmp++; if (bus.o_count !== 3'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", bus.o_count); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", bus.o_stall); end
        n_cmp++; if (bus.o_overflow !== 1'b0) begin n_bad++; $display("FAIL flush_ovf got %b want 0", bus.o_overflow); end
        n_cmp++; if (bus.o_data === 32'hD0) begin n_bad++; $display("FAIL flush_d0_leak got %h want not d0", bus.o_data); end
        step();
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_after_valid got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_count !== 3'd0) begin n_bad++; $display("FAIL flush_after_count got %0d want 0", bus.o_count); end
    endtask

    task automatic test_async_reset();
        bus.i_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.i_valid = 1'b1; bus.i_data = 32'h90 + 32'(i);
            step();
        end
        n_cmp++; if (bus.o_count !== 3'd2) begin n_bad++; $display("FAIL prerst_count got %0d want 2", bus.o_count); end
        n_cmp++; if (bus.o_data !== 32'h90) begin n_bad++; $display("FAIL prerst_head got %h want 90", bus.o_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_count !== 3'd0) begin n_bad++; $display("FAIL arst_count got %0d want 0", bus.o_count); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 32'h0) begin n_bad++; $display("FAIL arst_data got %h want 0", bus.o_data); end
        n_cmp++; if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL arst_stall got %b want 0", bus.o_stall); end
        n_cmp++; if (bus.o_overflow !== 1'b0) begin n_bad++; $display("FAIL arst_ovf got %b want 0", bus.o_overflow); end
        #4;
        rst_n = 1'b1;
        bus.i_stall = 1'b0; bus.i_valid = 1'b1; bus.i_data = 32'hE0;
        step();
        bus.i_valid = 1'b0;
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL postrst_valid got %b want 1", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 32'hE0) begin n_bad++; $display("FAIL postrst_data got %h want e0", bus.o_data); end
        n_cmp++; if (bus.o_count !== 3'd1) begin n_bad++; $display("FAIL postrst_count got %0d want 1", bus.o_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_back_to_back();
        test_fill_overflow();
        test_full_push_pop();
        test_drain();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
